noc_inject_arbiter: RTL and testbench

NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

---
 rtl/noc_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 36 +++
 rtl/noc_inject_arbiter.sv | 93 +++++++++
 tb/tb_noc_inject_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and index-width helpers for the NoC injection arbiter.
package noc_arb_pkg;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = idx_w(MAX_REQ);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester strictly after last_winner, wrapping.
module rr_pick
  import noc_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    last_winner,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any_valid
);

  logic found;
  int   j;

  always_comb begin
    pick      = '0;
    pick_idx  = '0;
    any_valid = |valid;
    found     = 1'b0;
    j         = 0;
    // k == N_REQ lands on last_winner itself, so a lone requester can re-win
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last_winner) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && valid[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter feeding the tile switch local-in port.
module noc_inject_arbiter
  import noc_arb_pkg::*;
#(
  parameter int BW    = 32,
  parameter int BWB   = BW / 8,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_high,
  input  logic                 arb_enable,
  input  logic [N_REQ-1:0]     req_TVALID,
  input  logic [N_REQ-1:0]     req_TLAST,
  input  logic [N_REQ*BW-1:0]  req_TDATA,
  input  logic [N_REQ*BWB-1:0] req_TKEEP,
  output logic [N_REQ-1:0]     req_TREADY,
  output logic                 out_TVALID,
  output logic                 out_TLAST,
  output logic [BW-1:0]        out_TDATA,
  output logic [BWB-1:0]       out_TKEEP,
  input  logic                 out_TREADY,
  output logic [N_REQ-1:0]     grant_onehot,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam int IW = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_n
    $error("noc_inject_arbiter: N_REQ out of range");
  end

  arb_state_t                   state;
  logic [IW-1:0]                last_winner;
  logic [N_REQ-1:0]             pick;
  logic [IW-1:0]                pick_idx;
  logic                         any_valid;
  logic [N_REQ-1:0][BW-1:0]     data_a;
  logic [N_REQ-1:0][BWB-1:0]    keep_a;

  assign data_a = req_TDATA;
  assign keep_a = req_TKEEP;
  assign busy   = (state == XFER);

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .valid       (req_TVALID),
    .last_winner (last_winner),
    .pick        (pick),
    .pick_idx    (pick_idx),
    .any_valid   (any_valid)
  );

  // last_winner doubles as the mux select while a packet is in flight
  always_comb begin
    out_TVALID = 1'b0;
    out_TLAST  = 1'b0;
    out_TDATA  = '0;
    out_TKEEP  = '0;
    req_TREADY = '0;
    if (state == XFER) begin
      out_TVALID = req_TVALID[last_winner];
      out_TLAST  = req_TLAST[last_winner];
      out_TDATA  = data_a[last_winner];
      out_TKEEP  = keep_a[last_winner];
      req_TREADY = grant_onehot & {N_REQ{out_TREADY}};
    end
  end

  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      state        <= IDLE;
      grant_onehot <= '0;
      last_winner  <= IW'(N_REQ - 1);
      pkt_count    <= '0;
    end else begin
      case (state)
        IDLE: if (arb_enable && any_valid) begin
          state        <= XFER;
          grant_onehot <= pick;
          last_winner  <= pick_idx;
        end
        XFER: if (out_TVALID && out_TREADY && out_TLAST) begin
          state        <= IDLE;
          grant_onehot <= '0;
          pkt_count    <= pkt_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter with hand-computed expectations.
module tb_noc_inject_arbiter;

  localparam int BW = 32, BWB = 4, N = 4, CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [N-1:0]         vld, lst;
  logic [N-1:0][BW-1:0] dat;
  logic [N-1:0][BWB-1:0] kp;
  logic [N-1:0]         rdy_o;
  logic                 ordy;
  logic                 o_vld, o_lst, busy;
  logic [BW-1:0]        o_dat;
  logic [BWB-1:0]       o_kp;
  logic [N-1:0]         grant;
  logic [CW-1:0]        pkt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  noc_inject_arbiter #(.BW(BW), .BWB(BWB), .N_REQ(N), .CNT_W(CW)) dut (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .arb_enable        (en),
    .req_TVALID        (vld),
    .req_TLAST         (lst),
    .req_TDATA         (dat),
    .req_TKEEP         (kp),
    .req_TREADY        (rdy_o),
    .out_TVALID        (o_vld),
    .out_TLAST         (o_lst),
    .out_TDATA         (o_dat),
    .out_TKEEP         (o_kp),
    .out_TREADY        (ordy),
    .grant_onehot      (grant),
    .busy              (busy),
    .pkt_count         (pkt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_g [5];
    int           exp_i [5];
    int           beat;
    rst = 1'b1; en = 1'b1; vld = '0; lst = '0; dat = '0; ordy = 1'b1;
    for (int i = 0; i < N; i++) kp[i] = BWB'(i + 1);
    tick(); tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_tvalid", o_vld, 0);
    chk("rst_tlast", o_lst, 0);
    chk("rst_tdata", o_dat, 0);
    chk("rst_tkeep", o_kp, 0);
    chk("rst_tready", rdy_o, 0);
    chk("rst_pkt", pkt, 0);
    rst = 1'b0;

    // single requester, 3-beat packet
    vld = 4'b0001; dat[0] = 32'hA000_0000; #1;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_tvalid", o_vld, 0);
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    chk("t1_b0_data", o_dat, 32'hA000_0000);
    chk("t1_b0_keep", o_kp, 4'h1);
    chk("t1_b0_tvalid", o_vld, 1);
    chk("t1_tready", rdy_o, 4'b0001);
    tick();
    dat[0] = 32'hA000_0001; #1;
    chk("t1_b1_data", o_dat, 32'hA000_0001);
    tick();
    dat[0] = 32'hA000_0002; lst[0] = 1'b1; #1;
    chk("t1_b2_data", o_dat, 32'hA000_0002);
    chk("t1_b2_last", o_lst, 1);
    tick();
    vld = '0; lst = '0; #1;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_grant", grant, 0);
    chk("t1_pkt", pkt, 1);

    // all requesters valid, single-beat packets: 0,1,2,3,0
    do_reset();
    vld = 4'b1111; lst = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'h5500_0000 + i;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{0, 1, 2, 3, 0};
    for (int p = 0; p < 5; p++) begin
      #1;
      chk("t2_idle_grant", grant, 0);
      tick();
      chk("t2_grant", grant, exp_g[p]);
      chk("t2_data", o_dat, 32'h5500_0000 + exp_i[p]);
      tick();
    end
    chk("t2_pkt", pkt, 5);
    vld = '0; lst = '0;

    // requester 2, 4 beats, out_TREADY toggling
    do_reset();
    vld = 4'b0100; dat[2] = 32'hC000_0000;
    tick();
    beat = 0;
    for (int c = 0; c < 7; c++) begin
      ordy = (c % 2 == 0);
      dat[2] = 32'hC000_0000 + beat;
      lst[2] = (beat == 3);
      #1;
      chk("t3_grant", grant, 4'b0100);
      chk("t3_data", o_dat, 32'hC000_0000 + beat);
      chk("t3_tready", rdy_o, ordy ? 4'b0100 : 4'b0000);
      tick();
      if (ordy) beat++;
    end
    chk("t3_done_busy", busy, 0);
    chk("t3_pkt", pkt, 1);
    vld = '0; lst = '0; ordy = 1'b1;

    // arb_enable dropped mid-packet, requester 3 waits
    do_reset();
    vld = 4'b1010; dat[3] = 32'hD300_0000; lst[3] = 1'b1;
    tick();
    chk("t4_grant1", grant, 4'b0010);
    for (int b = 0; b < 5; b++) begin
      dat[1] = 32'hB100_0000 + b;
      lst[1] = (b == 4);
      if (b == 1) en = 1'b0;
      #1;
      chk("t4_data", o_dat, 32'hB100_0000 + b);
      chk("t4_hold", grant, 4'b0010);
      tick();
    end
    vld[1] = 1'b0; lst[1] = 1'b0;
    chk("t4_pkt1", pkt, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_disabled_grant", grant, 0);
      chk("t4_disabled_busy", busy, 0);
    end
    en = 1'b1; #1;
    chk("t4_pre_grant", grant, 0);
    tick();
    chk("t4_grant3", grant, 4'b1000);
    chk("t4_data3", o_dat, 32'hD300_0000);
    tick();
    chk("t4_pkt2", pkt, 2);
    vld = '0; lst = '0;

    // asynchronous reset mid-packet
    vld = 4'b0001; dat[0] = 32'hE000_0000;
    tick();
    chk("t5_grant", grant, 4'b0001);
    tick();
    dat[0] = 32'hE000_0001; #1;
    chk("t5_b1_data", o_dat, 32'hE000_0001);
    #2;
    rst = 1'b1; #1;
    chk("t5_rst_tvalid", o_vld, 0);
    chk("t5_rst_tdata", o_dat, 0);
    chk("t5_rst_tkeep", o_kp, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_tready", rdy_o, 0);
    chk("t5_rst_pkt", pkt, 0);
    tick();
    rst = 1'b0; vld = 4'b1001; lst = 4'b1001; dat[3] = 32'hD300_0003; #1;
    chk("t5_post_idle", grant, 0);
    tick();
    chk("t5_post_grant", grant, 4'b0001);
    vld = '0; lst = '0;

    // counter wrap with CNT_W=4
    do_reset();
    vld = 4'b0001; lst = 4'b0001; dat[0] = 32'hF000_0000;
    for (int p = 0; p < 17; p++) begin
      tick(); tick();
      if (p == 15) chk("t6_wrap0", pkt, 0);
    end
    chk("t6_pkt", pkt, 1);
    vld = '0; lst = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
